// File: rtl/dlf_iir_seq.sv
// ADPLL digital loop filter: direct-form IIR of order ORDER evaluated on one shared MAC.
// Define DLF_GEARSHIFT_EN to add a second coefficient bank selected per sample by gear.
module dlf_iir_seq #(
    parameter int unsigned IO_W      = 8,
    parameter int unsigned COEF_INT  = 2,
    parameter int unsigned COEF_FRAC = 18,
    parameter int unsigned ORDER     = 3
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IO_W-1:0]               in_mag,
    input  logic                          lead,
    input  logic                          freeze,
    input  logic                          gear,
    input  logic                          coef_we,
    input  logic [4:0]                    coef_addr,
    input  logic [COEF_INT+COEF_FRAC-1:0] coef_wdata,
    output logic                          out_valid,
    output logic [IO_W-1:0]               out_code,
    output logic                          sat_flag
);
    localparam int unsigned COEF_W = COEF_INT + COEF_FRAC;
    localparam int unsigned SMP_W  = IO_W + 1;
    localparam int unsigned PROD_W = SMP_W + COEF_W;
    localparam int unsigned ACC_W  = IO_W + COEF_W + 4;
    localparam int unsigned NCOEF  = 2 * ORDER + 1;
`ifdef DLF_GEARSHIFT_EN
    localparam int unsigned NBANK  = 2;
`else
    localparam int unsigned NBANK  = 1;
`endif
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << IO_W) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {StIdle, StMac, StRound, StOut} state_e;

    state_e                   state_q, state_d;
    logic [3:0]               idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [SMP_W-1:0]  x_q;
    logic                     frz_q;
    logic                     bank_q;
    logic signed [SMP_W-1:0]  xh_q [ORDER];
    logic signed [SMP_W-1:0]  yh_q [ORDER];
    logic signed [COEF_W-1:0] coef_q [NBANK][NCOEF];
    logic [IO_W-1:0]          out_code_q;
    logic                     sat_q;

    logic                     wr_bank;
    logic                     gear_sel;
    logic signed [SMP_W-1:0]  x_in;
    logic signed [SMP_W-1:0]  mac_x;
    logic signed [COEF_W-1:0] mac_c;
    logic                     mac_sub;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [SMP_W-1:0]  y_new;
    logic                     y_clamp;
    logic [IO_W-1:0]          code_new;
    logic                     code_clamp;

`ifdef DLF_GEARSHIFT_EN
    assign wr_bank  = coef_addr[4];
    assign gear_sel = gear;
`else
    logic unused_gear;
    assign wr_bank     = 1'b0;
    assign gear_sel    = 1'b0;
    assign unused_gear = gear ^ coef_addr[4];
`endif

    assign x_in = lead ? $signed({1'b0, in_mag}) : -$signed({1'b0, in_mag});

    // MAC step idx: 0 -> b0*x[n], 1..N -> bk*x[n-k], N+1..2N -> ak*y[n-k] (subtracted)
    always_comb begin
        mac_x   = x_q;
        mac_c   = '0;
        mac_sub = 1'b0;
        for (int k = 0; k < ORDER; k++) begin
            if (idx_q == 4'(k + 1)) mac_x = xh_q[k];
            if (idx_q == 4'(k + ORDER + 1)) begin
                mac_x   = yh_q[k];
                mac_sub = 1'b1;
            end
        end
        for (int b = 0; b < NBANK; b++) begin
            for (int k = 0; k < NCOEF; k++) begin
                if (bank_q == 1'(b) && idx_q == 4'(k)) mac_c = coef_q[b][k];
            end
        end
    end

    assign prod     = PROD_W'(mac_x) * PROD_W'(mac_c);
    assign prod_ext = ACC_W'(prod);

    always_comb begin
        shifted    = acc_q >>> COEF_FRAC;
        y_new      = shifted[SMP_W-1:0];
        y_clamp    = 1'b0;
        if (shifted > Y_MAX) begin
            y_new   = SMP_W'(Y_MAX);
            y_clamp = 1'b1;
        end else if (shifted < Y_MIN) begin
            y_new   = SMP_W'(Y_MIN);
            y_clamp = 1'b1;
        end
        code_new   = y_new[IO_W-1:0];
        code_clamp = 1'b0;
        if (y_new[SMP_W-1]) begin
            code_new   = '0;
            code_clamp = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StMac;
            StMac:   if (idx_q == 4'(NCOEF - 1)) state_d = StRound;
            StRound: state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            acc_q      <= '0;
            x_q        <= '0;
            frz_q      <= 1'b0;
            bank_q     <= 1'b0;
            out_code_q <= '0;
            sat_q      <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                xh_q[k] <= '0;
                yh_q[k] <= '0;
            end
            for (int b = 0; b < NBANK; b++) begin
                for (int k = 0; k < NCOEF; k++) coef_q[b][k] <= '0;
            end
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_q    <= x_in;
                        frz_q  <= freeze;
                        bank_q <= gear_sel;
                        acc_q  <= '0;
                        idx_q  <= '0;
                    end else if (coef_we) begin
                        // Out-of-range indices match no entry and are dropped.
                        for (int b = 0; b < NBANK; b++) begin
                            for (int k = 0; k < NCOEF; k++) begin
                                if (wr_bank == 1'(b) && coef_addr[3:0] == 4'(k)) begin
                                    coef_q[b][k] <= coef_wdata;
                                end
                            end
                        end
                    end
                end
                StMac: begin
                    acc_q <= mac_sub ? acc_q - prod_ext : acc_q + prod_ext;
                    idx_q <= idx_q + 4'd1;
                end
                StRound: begin
                    if (!frz_q) begin
                        xh_q[0] <= x_q;
                        yh_q[0] <= y_new;
                        for (int k = 1; k < ORDER; k++) begin
                            xh_q[k] <= xh_q[k-1];
                            yh_q[k] <= yh_q[k-1];
                        end
                        out_code_q <= code_new;
                        sat_q      <= y_clamp | code_clamp;
                    end
                end
                StOut: ;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StOut);
    assign out_code  = out_code_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_dlf_iir_seq.sv
// Self-checking bench for dlf_iir_seq: vector table driven through a scoreboard queue,
// plus hand sequences for throughput, busy writes and mid-MAC reset.
module tb_dlf_iir_seq;
    localparam int IO_W      = 8;
    localparam int COEF_INT  = 2;
    localparam int COEF_FRAC = 18;
    localparam int ORDER     = 3;
    localparam int COEF_W    = COEF_INT + COEF_FRAC;
    localparam int LAT       = 2 * ORDER + 2;
    localparam int PERIOD    = 2 * ORDER + 4;
`ifdef DLF_GEARSHIFT_EN
    localparam int GEAR0_EXP = 100;
`else
    localparam int GEAR0_EXP = 50;
`endif
    localparam logic [COEF_W-1:0] ONE      = 20'h40000;
    localparam logic [COEF_W-1:0] HALF     = 20'h20000;
    localparam logic [COEF_W-1:0] NEG_ONE  = 20'hC0000;
    localparam logic [COEF_W-1:0] NEG_HALF = 20'hE0000;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IO_W-1:0]   in_mag = '0;
    logic              lead = 1'b0;
    logic              freeze = 1'b0;
    logic              gear = 1'b0;
    logic              coef_we = 1'b0;
    logic [4:0]        coef_addr = '0;
    logic [COEF_W-1:0] coef_wdata = '0;
    logic              out_valid;
    logic [IO_W-1:0]   out_code;
    logic              sat_flag;

    dlf_iir_seq #(
        .IO_W      (IO_W),
        .COEF_INT  (COEF_INT),
        .COEF_FRAC (COEF_FRAC),
        .ORDER     (ORDER)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mag     (in_mag),
        .lead       (lead),
        .freeze     (freeze),
        .gear       (gear),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .out_valid  (out_valid),
        .out_code   (out_code),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int code;
        int sat;
        int k;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int cfg;
        int mag;
        bit lead;
        bit frz;
        bit gear;
        int code;
        int sat;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard on every out_valid cycle.
    bit prev_ov = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rstn && out_valid) begin
            check("out_valid_one_cycle", int'(prev_ov), 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: out_valid with code %0d, expected none", out_code);
            end else begin
                e = sb.pop_front();
                check("out_code", int'(out_code), e.code);
                check("sat_flag", int'(sat_flag), e.sat);
                check("latency", cyc - e.k, LAT);
            end
        end
        prev_ov <= rstn && out_valid;
    end

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
    task automatic send(input int mag, input bit ld, input bit frz, input bit gr,
                        input int code, input int sat, output int k, output int waits);
        in_mag   = IO_W'(mag);
        lead     = ld;
        freeze   = frz;
        gear     = gr;
        in_valid = 1'b1;
        waits    = 0;
        while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready still %0d, expected 1", in_ready);
            in_valid = 1'b0;
            k = -1;
        end else begin
            k = cyc + 1;
            sb.push_back('{code, sat, k});
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pending_outputs", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn     = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic write_coef(input logic [4:0] addr, input logic [COEF_W-1:0] data);
        int n = 0;
        in_valid = 1'b0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        coef_addr  = addr;
        coef_wdata = data;
        coef_we    = 1'b1;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic load_cfg(input int cfg);
        drain();
        do_reset();
        case (cfg)
            1: write_coef(5'd0, ONE);
            2: begin write_coef(5'd0, ONE); write_coef(5'd4, NEG_ONE); end
            3: begin write_coef(5'd0, HALF); write_coef(5'd1, HALF); write_coef(5'd3, ONE); end
            4: begin write_coef(5'd0, ONE); write_coef(5'd5, NEG_HALF); end
            5: begin write_coef(5'd0, ONE); write_coef(5'h10, HALF); end
            default: ;
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, k1, k2, w0, w1, w2, cur_cfg;

        // cfg: 1 pass-through, 2 integrator, 3 FIR taps b0/b1/b3, 4 a2 feedback, 5 gear banks
        vecs.push_back('{1, 100, 1'b1, 1'b0, 1'b0, 100, 0});
        vecs.push_back('{1,   5, 1'b0, 1'b0, 1'b0,   0, 1});
        vecs.push_back('{1,   0, 1'b1, 1'b0, 1'b0,   0, 0});
        vecs.push_back('{1, 255, 1'b1, 1'b0, 1'b0, 255, 0});
        vecs.push_back('{2, 100, 1'b1, 1'b0, 1'b0, 100, 0});
        vecs.push_back('{2, 100, 1'b1, 1'b0, 1'b0, 200, 0});
        vecs.push_back('{2, 100, 1'b1, 1'b0, 1'b0, 255, 1});
        vecs.push_back('{2, 200, 1'b0, 1'b0, 1'b0,  55, 0});
        vecs.push_back('{2,  50, 1'b1, 1'b1, 1'b0,  55, 0});
        vecs.push_back('{2,  55, 1'b0, 1'b0, 1'b0,   0, 0});
        vecs.push_back('{3, 100, 1'b1, 1'b0, 1'b0,  50, 0});
        vecs.push_back('{3,  50, 1'b1, 1'b0, 1'b0,  75, 0});
        vecs.push_back('{3,  20, 1'b1, 1'b0, 1'b0,  35, 0});
        vecs.push_back('{3,  10, 1'b1, 1'b0, 1'b0, 115, 0});
        vecs.push_back('{3,  31, 1'b0, 1'b0, 1'b0,  39, 0});
        vecs.push_back('{3,  10, 1'b0, 1'b0, 1'b0,   0, 1});
        vecs.push_back('{4, 100, 1'b1, 1'b0, 1'b0, 100, 0});
        vecs.push_back('{4,   0, 1'b1, 1'b0, 1'b0,   0, 0});
        vecs.push_back('{4,   0, 1'b1, 1'b0, 1'b0,  50, 0});
        vecs.push_back('{4,   0, 1'b1, 1'b0, 1'b0,   0, 0});
        vecs.push_back('{4,   0, 1'b1, 1'b0, 1'b0,  25, 0});
        vecs.push_back('{5, 100, 1'b1, 1'b0, 1'b1,  50, 0});
        vecs.push_back('{5, 100, 1'b1, 1'b0, 1'b0, GEAR0_EXP, 0});

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_code", int'(out_code), 0);
        check("rst_sat_flag", int'(sat_flag), 0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);

        cur_cfg = 0;
        foreach (vecs[i]) begin
            if (vecs[i].cfg != cur_cfg) begin
                load_cfg(vecs[i].cfg);
                cur_cfg = vecs[i].cfg;
            end
            send(vecs[i].mag, vecs[i].lead, vecs[i].frz, vecs[i].gear,
                 vecs[i].code, vecs[i].sat, k0, w0);
            in_valid = 1'b0;
        end
        drain();

        // Back-to-back with in_valid held high
        load_cfg(1);
        send(10, 1'b1, 1'b0, 1'b0, 10, 0, k0, w0);
        send(20, 1'b1, 1'b0, 1'b0, 20, 0, k1, w1);
        send(30, 1'b1, 1'b0, 1'b0, 30, 0, k2, w2);
        in_valid = 1'b0;
        check("b2b_period_1", k1 - k0, PERIOD);
        check("b2b_period_2", k2 - k1, PERIOD);
        check("ready_low_1", w1, PERIOD - 1);
        check("ready_low_2", w2, PERIOD - 1);
        drain();

        // Coefficient writes during MAC and on the accepting edge are ignored
        send(100, 1'b1, 1'b0, 1'b0, 100, 0, k0, w0);
        in_valid   = 1'b0;
        coef_addr  = 5'd0;
        coef_wdata = HALF;
        coef_we    = 1'b1;
        repeat (3) @(negedge clk);
        coef_we = 1'b0;
        drain();
        coef_we = 1'b1;
        send(100, 1'b1, 1'b0, 1'b0, 100, 0, k0, w0);
        coef_we  = 1'b0;
        in_valid = 1'b0;
        drain();
        send(100, 1'b1, 1'b0, 1'b0, 100, 0, k0, w0);
        in_valid = 1'b0;
        drain();

        // Reset asserted mid-MAC
        send(77, 1'b1, 1'b0, 1'b0, 77, 0, k0, w0);
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mac_rst_in_ready", int'(in_ready), 1);
        check("mac_rst_out_valid", int'(out_valid), 0);
        check("mac_rst_out_code", int'(out_code), 0);
        check("mac_rst_sat_flag", int'(sat_flag), 0);
        rstn = 1'b1;
        @(negedge clk);
        // Coefficients were cleared, so the first sample after reset yields zero
        send(100, 1'b1, 1'b0, 1'b0, 0, 0, k0, w0);
        in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
